// File: rtl/pwm_heater_driver.sv
// pwm_heater_driver: time-proportioned heater/cooler switching with dead band.
// Converts an 8-bit drive level and a cooling-request flag into registered
// heat/cool switch outputs. A PWM period is 255 steps of PRESCALE cycles each.
// Build option: define PWM_DRIVER_COOL_EN to enable the DEAD/COOL path;
// without it, neg is ignored and cool is held at 0.
module pwm_heater_driver #(
  parameter int unsigned PRESCALE         = 1000,
  parameter int unsigned COOL_MIN_PERIODS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] level,
  input  logic       neg,
  output logic       heat,
  output logic       cool,
  output logic       period_start,
  output logic [7:0] duty,
  output logic [1:0] mode
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 8;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(254);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    DEAD = 2'd2,
    COOL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] step_q, step_d;
  logic [SW-1:0] duty_q, duty_d;
  logic          heat_d, cool_d, pstart_d;
  logic          boundary_c;

`ifdef PWM_DRIVER_COOL_EN
  logic [CW-1:0] cperiods_q, cperiods_d;
`else
  logic unused_cfg;
  assign unused_cfg = neg ^ (COOL_MIN_PERIODS == 0) ^ (CW == 0);
`endif

  assign duty = duty_q;
  assign mode = state_q;

  // State, counter and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      step_q       <= '0;
      duty_q       <= '0;
      heat         <= 1'b0;
      cool         <= 1'b0;
      period_start <= 1'b0;
`ifdef PWM_DRIVER_COOL_EN
      cperiods_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      step_q       <= step_d;
      duty_q       <= duty_d;
      heat         <= heat_d;
      cool         <= cool_d;
      period_start <= pstart_d;
`ifdef PWM_DRIVER_COOL_EN
      cperiods_q   <= cperiods_d;
`endif
    end
  end

  // Next-state: counters, period boundary, mode transitions and switch outputs
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    step_d     = step_q;
    duty_d     = duty_q;
    pstart_d   = 1'b0;
    heat_d     = 1'b0;
    cool_d     = 1'b0;
`ifdef PWM_DRIVER_COOL_EN
    cperiods_d = cperiods_q;
`endif
    boundary_c = enable &&
                 ((state_q == IDLE) || ((presc_q == PRESC_LAST) && (step_q == STEP_LAST)));

    if (!enable) begin
      state_d    = IDLE;
      presc_d    = '0;
      step_d     = '0;
      duty_d     = '0;
`ifdef PWM_DRIVER_COOL_EN
      cperiods_d = '0;
`endif
    end else if (boundary_c) begin
      presc_d  = '0;
      step_d   = '0;
      duty_d   = level;
      pstart_d = 1'b1;
`ifdef PWM_DRIVER_COOL_EN
      case (state_q)
        IDLE:    state_d = neg ? COOL : HEAT;
        HEAT:    if (neg) state_d = DEAD;
        DEAD:    state_d = neg ? COOL : HEAT;
        COOL:    if (!neg && (cperiods_q >= CW'(COOL_MIN_PERIODS))) state_d = DEAD;
        default: state_d = IDLE;
      endcase
      // Count completed cooling periods; restart the count on each COOL entry
      if ((state_q == COOL) && (cperiods_q != {CW{1'b1}})) begin
        cperiods_d = cperiods_q + CW'(1);
      end
      if ((state_d == COOL) && (state_q != COOL)) begin
        cperiods_d = '0;
      end
`else
      case (state_q)
        IDLE:    state_d = HEAT;
        HEAT:    state_d = HEAT;
        default: state_d = IDLE;
      endcase
`endif
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      step_d  = step_q + SW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Outputs are derived from next-cycle values so they register with the counters
    heat_d = (state_d == HEAT) && (step_d < duty_d);
`ifdef PWM_DRIVER_COOL_EN
    cool_d = (state_d == COOL);
`endif
  end

endmodule

// File: tb/tb_pwm_heater_driver.sv
// Self-checking bench for pwm_heater_driver (PRESCALE=2, COOL_MIN_PERIODS=4).
// Cooling scenarios are exercised when PWM_DRIVER_COOL_EN is defined.
module tb_pwm_heater_driver;

  localparam int PRE  = 2;
  localparam int CMIN = 4;
  localparam int PER  = 255 * PRE;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] level;
  logic       neg;
  logic       heat, cool, period_start;
  logic [7:0] duty;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_heater_driver #(.PRESCALE(PRE), .COOL_MIN_PERIODS(CMIN)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .level       (level),
    .neg         (neg),
    .heat        (heat),
    .cool        (cool),
    .period_start(period_start),
    .duty        (duty),
    .mode        (mode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position within the period in cycles, latched duty, mode
  int m_t, m_mode, m_duty, m_cp;
  bit m_ps;
  always @(posedge clock or negedge reset) begin
    int old;
    if (!reset) begin
      m_t = 0; m_mode = 0; m_duty = 0; m_cp = 0; m_ps = 0;
    end else if (!enable) begin
      m_t = 0; m_mode = 0; m_duty = 0; m_cp = 0; m_ps = 0;
    end else if (m_mode == 0 || m_t == PER - 1) begin
      old = m_mode;
      m_t = 0; m_duty = int'(level); m_ps = 1;
`ifdef PWM_DRIVER_COOL_EN
      case (old)
        0: m_mode = neg ? 3 : 1;
        1: if (neg) m_mode = 2;
        2: m_mode = neg ? 3 : 1;
        default: begin
          if (!neg && m_cp >= CMIN) m_mode = 2;
          if (m_cp < 255) m_cp++;
        end
      endcase
      if (m_mode == 3 && old != 3) m_cp = 0;
`else
      m_mode = 1;
`endif
    end else begin
      m_t++; m_ps = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    chk("cyc_heat", int'(heat), int'(m_mode == 1 && m_t < m_duty * PRE));
    chk("cyc_cool", int'(cool), int'(m_mode == 3));
    chk("cyc_pstart", int'(period_start), int'(m_ps));
    chk("cyc_duty", int'(duty), m_duty);
    chk("cyc_mode", int'(mode), m_mode);
    chk("cyc_excl", int'(heat && cool), 0);
  end

  // Count heat/cool cycles from now until the next period_start
  task automatic measure(output int hc, output int cc, output int len);
    hc = 0; cc = 0; len = 0;
    do begin
      hc += int'(heat); cc += int'(cool); len++;
      @(negedge clock);
    end while (!period_start && len < 3000);
    chk("meas_timeout", int'(len < 3000), 1);
  endtask

  initial begin
    int hc, cc, len, np;
    reset = 1'b0; enable = 1'b0; level = 8'h00; neg = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_heat", int'(heat), 0);
    chk("rst_cool", int'(cool), 0);
    chk("rst_pstart", int'(period_start), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_mode", int'(mode), 0);

    reset = 1'b1; enable = 1'b1; level = 8'h40;
    @(negedge clock);
    chk("first_pstart", int'(period_start), 1);
    chk("first_heat", int'(heat), 1);
    chk("first_mode", int'(mode), 1);
    chk("first_duty", int'(duty), 8'h40);
    measure(hc, cc, len);
    chk("p1_len", len, 510);
    chk("p1_heat", hc, 128);
    chk("p1_cool", cc, 0);

    level = 8'hFF;
    measure(hc, cc, len);
    chk("p2_heat_unchanged", hc, 128);
    chk("p3_duty", int'(duty), 255);
    level = 8'h00;
    measure(hc, cc, len);
    chk("p3_heat_full", hc, 510);
    chk("p3_len", len, 510);
    chk("p4_duty", int'(duty), 0);
    level = 8'h80;
    measure(hc, cc, len);
    chk("p4_heat_zero", hc, 0);

    repeat (20) @(negedge clock);
    chk("mid_heat", int'(heat), 1);
    enable = 1'b0;
    @(negedge clock);
    chk("dis_heat", int'(heat), 0);
    chk("dis_cool", int'(cool), 0);
    chk("dis_mode", int'(mode), 0);
    chk("dis_duty", int'(duty), 0);
    chk("dis_pstart", int'(period_start), 0);
    enable = 1'b1;
    @(negedge clock);
    chk("re_pstart", int'(period_start), 1);
    chk("re_heat", int'(heat), 1);
    chk("re_duty", int'(duty), 8'h80);
    measure(hc, cc, len);
    chk("re_len", len, 510);
    chk("re_heat_cnt", hc, 256);

`ifdef PWM_DRIVER_COOL_EN
    level = 8'h40; neg = 1'b1;
    measure(hc, cc, len);
    chk("negrise_heat", hc, 256);
    chk("dead_mode", int'(mode), 2);
    measure(hc, cc, len);
    chk("dead_heat", hc, 0);
    chk("dead_cool", cc, 0);
    chk("dead_len", len, 510);
    chk("cool_mode", int'(mode), 3);
    measure(hc, cc, len);
    chk("cool_cnt", cc, 510);
    neg = 1'b0;
    np = 1;
    while (mode == 2'd3 && np < 20) begin
      measure(hc, cc, len);
      chk("cool_hold", cc, 510);
      np++;
    end
    chk("cool_min", int'(np >= CMIN), 1);
    chk("cool_exit_dead", int'(mode), 2);
    measure(hc, cc, len);
    chk("dead2_heat", hc, 0);
    chk("dead2_cool", cc, 0);
    chk("back_heat_mode", int'(mode), 1);
    measure(hc, cc, len);
    chk("back_heat_cnt", hc, 128);

    neg = 1'b1;
    measure(hc, cc, len);
    measure(hc, cc, len);
    repeat (30) @(negedge clock);
    chk("pre_rst_cool", int'(cool), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_cool", int'(cool), 0);
    chk("async_mode", int'(mode), 0);
    chk("async_duty", int'(duty), 0);
`else
    neg = 1'b1; level = 8'h80;
    measure(hc, cc, len);
    chk("nc_heat1", hc, 256);
    chk("nc_mode", int'(mode), 1);
    measure(hc, cc, len);
    chk("nc_heat2", hc, 256);
    chk("nc_cool", cc, 0);
    chk("nc_len", len, 510);
    repeat (10) @(negedge clock);
    chk("pre_rst_heat", int'(heat), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_heat", int'(heat), 0);
    chk("async_mode", int'(mode), 0);
    chk("async_duty", int'(duty), 0);
`endif
    repeat (3) @(negedge clock);
    chk("rst_hold_heat", int'(heat), 0);
    chk("rst_hold_cool", int'(cool), 0);
    chk("rst_hold_pstart", int'(period_start), 0);
    neg = 1'b0; level = 8'h10;
    reset = 1'b1;
    @(negedge clock);
    chk("rel_pstart", int'(period_start), 1);
    chk("rel_duty", int'(duty), 8'h10);
    measure(hc, cc, len);
    chk("rel_heat_cnt", hc, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
